// File: rtl/dmem_stream_if.sv
// CPU data-port and UART dump-stream signal bundle for dmem_stream; slave = memory side.
// byte_en exists only when DMEM_BYTE_EN is defined.
interface dmem_stream_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              write_en;
  logic              read_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              addr_err;
`ifdef DMEM_BYTE_EN
  logic [DATA_W/8-1:0] byte_en;
`endif
  logic              dump_start;
  logic              dump_busy;
  logic              dump_done;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;

  modport master (
`ifdef DMEM_BYTE_EN
    output byte_en,
`endif
    output write_en, read_en, address, data_in, dump_start, tx_ready,
    input  data_out, addr_err, dump_busy, dump_done, tx_valid, tx_data
  );

  modport slave (
`ifdef DMEM_BYTE_EN
    input  byte_en,
`endif
    input  write_en, read_en, address, data_in, dump_start, tx_ready,
    output data_out, addr_err, dump_busy, dump_done, tx_valid, tx_data
  );
endinterface

// File: rtl/dmem_stream.sv
// Data memory with exact range check and a dump engine streaming DUMP_LEN words from DUMP_BASE.
// Latency: async read; dump_start -> tx_valid in 2 cycles, 2 cycles/word at full rate.
// Backpressure: tx_data/tx_valid held until tx_ready; CPU port never stalls. Option: DMEM_BYTE_EN.
module dmem_stream #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 16
) (
  input  logic          clk,
  input  logic          rst,
  dmem_stream_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(DUMP_LEN + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_ptr;
  logic [BW-1:0]     r_beat;
  logic              r_tx_valid;
  logic [DATA_W-1:0] r_tx_data;

  logic              w_in_range;
  logic [AW-1:0]     w_idx;
  logic              w_wr;
  logic [DATA_W-1:0] w_wr_dat;
  logic              w_accept;

  // Any set bit above the index field means the word does not exist.
  generate
    if (ADDR_W > AW) begin : g_rng
      assign w_in_range = (bus.address[ADDR_W-1:AW] == '0);
    end else begin : g_full
      assign w_in_range = 1'b1;
    end
  endgenerate

  assign w_idx        = bus.address[AW-1:0];
  assign bus.data_out = w_in_range ? r_mem[w_idx] : '0;
  assign bus.addr_err = (bus.read_en | bus.write_en) & ~w_in_range;
  assign w_wr         = bus.write_en & w_in_range;

`ifdef DMEM_BYTE_EN
  always_comb begin
    w_wr_dat = r_mem[w_idx];
    for (int k = 0; k < DATA_W/8; k++) begin
      if (bus.byte_en[k]) w_wr_dat[8*k +: 8] = bus.data_in[8*k +: 8];
    end
  end
`else
  assign w_wr_dat = bus.data_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[w_idx] <= w_wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE:  if (bus.dump_start) w_state_nxt = FETCH;
      FETCH: w_state_nxt = SEND;
      SEND: begin
        w_accept = r_tx_valid & bus.tx_ready;
        if (w_accept) begin
          w_state_nxt = (r_beat == BW'(DUMP_LEN - 1)) ? DONE : FETCH;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FETCH snapshots the word, so CPU writes during SEND cannot disturb tx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= AW'(DUMP_BASE);
      r_beat     <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.dump_start) begin
            r_ptr  <= AW'(DUMP_BASE);
            r_beat <= '0;
          end
        end
        FETCH: begin
          r_tx_data  <= r_mem[r_ptr];
          r_tx_valid <= 1'b1;
        end
        SEND: begin
          if (w_accept) begin
            r_tx_valid <= 1'b0;
            r_ptr      <= r_ptr + 1'b1;
            r_beat     <= r_beat + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_data   = r_tx_data;
  assign bus.dump_busy = (r_state != IDLE);
  assign bus.dump_done = (r_state == DONE);
endmodule

// File: tb/tb_dmem_stream.sv
// Bench for dmem_stream: default instance plus a wrapping DUMP_BASE=1022/DUMP_LEN=4 instance.
module tb_dmem_stream;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  logic rst_w;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_stream_if #(.DATA_W(DW), .ADDR_W(AW)) m_if ();
  dmem_stream_if #(.DATA_W(DW), .ADDR_W(AW)) w_if ();

  dmem_stream #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .DUMP_BASE(0), .DUMP_LEN(16))
    u_dut (.clk(clk), .rst(rst), .bus(m_if));
  dmem_stream #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1024), .DUMP_BASE(1022), .DUMP_LEN(4))
    u_wrap (.clk(clk), .rst(rst_w), .bus(w_if));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_m[$];
  logic [31:0] sb_w[$];
  int done_m = 0, done_w = 0, done_cyc_m = -1, first_rise_m = -1, acc_w = 0;
  logic prev_v_m = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Main-instance monitor: timestamps and pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (m_if.tx_valid && !prev_v_m && first_rise_m < 0) first_rise_m = cyc;
    prev_v_m = m_if.tx_valid;
    if (m_if.dump_done) begin
      done_m++;
      done_cyc_m = cyc;
    end
    if (m_if.tx_valid && m_if.tx_ready) begin
      if (sb_m.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected_m: got word %h with empty scoreboard", m_if.tx_data);
      end else begin
        chk("tx_data_m", m_if.tx_data, sb_m.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (w_if.dump_done) done_w++;
    if (w_if.tx_valid && w_if.tx_ready) begin
      acc_w++;
      if (sb_w.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected_w: got word %h with empty scoreboard", w_if.tx_data);
      end else begin
        chk("tx_data_w", w_if.tx_data, sb_w.pop_front());
      end
    end
  end

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    m_if.write_en = 1'b1;
    m_if.address  = a;
    m_if.data_in  = d;
    tick();
    m_if.write_en = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    m_if.read_en = 1'b1;
    m_if.address = a;
    #1;
    chk(nm, m_if.data_out, exp);
    m_if.read_en = 1'b0;
  endtask

  task automatic w_write(input logic [31:0] a, input logic [31:0] d);
    w_if.write_en = 1'b1;
    w_if.address  = a;
    w_if.data_in  = d;
    tick();
    w_if.write_en = 1'b0;
  endtask

  initial begin
    int start_cyc, d0, a0;
    logic [31:0] widx [4];
    widx[0] = 32'd1022; widx[1] = 32'd1023; widx[2] = 32'd0; widx[3] = 32'd1;

    rst = 1'b1; rst_w = 1'b1;
    m_if.write_en = 0; m_if.read_en = 0; m_if.address = 0; m_if.data_in = 0;
    m_if.dump_start = 0; m_if.tx_ready = 0;
    w_if.write_en = 0; w_if.read_en = 0; w_if.address = 0; w_if.data_in = 0;
    w_if.dump_start = 0; w_if.tx_ready = 1;
`ifdef DMEM_BYTE_EN
    m_if.byte_en = '1;
    w_if.byte_en = '1;
`endif
    repeat (2) tick();
    rst = 1'b0; rst_w = 1'b0;

    chk("rst_tx_valid", m_if.tx_valid, 0);
    chk("rst_tx_data", m_if.tx_data, 0);
    chk("rst_busy", m_if.dump_busy, 0);
    chk("rst_done", m_if.dump_done, 0);

    cpu_write(5, 32'hDEADBEEF);
    rd_chk("write_rd5", 5, 32'hDEADBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_chk("rst_clears5", 5, 0);
    chk("rst2_tx_valid", m_if.tx_valid, 0);
    chk("rst2_busy", m_if.dump_busy, 0);

    cpu_write(1023, 32'h1234);
    rd_chk("edge_rd1023", 1023, 32'h1234);
    chk("edge_err1023", m_if.addr_err, 0);
    m_if.write_en = 1'b1; m_if.address = 1024; m_if.data_in = 32'h55;
    #1;
    chk("oob_wr_err", m_if.addr_err, 1);
    chk("oob_wr_data", m_if.data_out, 0);
    tick();
    m_if.write_en = 1'b0;
    #1;
    chk("oob_idle_err", m_if.addr_err, 0);
    m_if.read_en = 1'b1;
    #1;
    chk("oob_rd_err", m_if.addr_err, 1);
    m_if.read_en = 1'b0;
    rd_chk("oob_no_alias0", 0, 0);

    // Free-flowing dump of i*3 with a stray dump_start while busy.
    for (int i = 0; i < 16; i++) begin
      cpu_write(i, i * 3);
      sb_m.push_back(i * 3);
    end
    m_if.tx_ready = 1'b1;
    first_rise_m = -1;
    d0 = done_m;
    start_cyc = cyc;
    m_if.dump_start = 1'b1;
    tick();
    m_if.dump_start = 1'b0;
    repeat (3) tick();
    m_if.dump_start = 1'b1;
    tick();
    m_if.dump_start = 1'b0;
    for (int i = 0; i < 100 && done_m == d0; i++) tick();
    repeat (3) tick();
    chk("ff_first_valid", first_rise_m - start_cyc, 2);
    chk("ff_done_cycle", done_cyc_m - start_cyc, 33);
    chk("ff_done_count", done_m - d0, 1);
    chk("ff_sb_empty", sb_m.size(), 0);

    // Backpressure: hold word 0 while overwriting it and word 1.
    m_if.tx_ready = 1'b0;
    sb_m.push_back(0);
    sb_m.push_back(32'h777);
    for (int i = 2; i < 16; i++) sb_m.push_back(i * 3);
    d0 = done_m;
    m_if.dump_start = 1'b1;
    tick();
    m_if.dump_start = 1'b0;
    for (int i = 0; i < 20 && !m_if.tx_valid; i++) tick();
    for (int k = 0; k < 10; k++) begin
      chk("bp_hold_data", m_if.tx_data, 0);
      chk("bp_hold_valid", m_if.tx_valid, 1);
      if (k == 3) begin
        m_if.write_en = 1'b1; m_if.address = 0; m_if.data_in = 32'hABCD;
      end else if (k == 4) begin
        m_if.address = 1; m_if.data_in = 32'h777;
      end else begin
        m_if.write_en = 1'b0;
      end
      tick();
    end
    chk("bp_snapshot", m_if.tx_data, 0);
    rd_chk("bp_cpu_wr0", 0, 32'hABCD);
    m_if.tx_ready = 1'b1;
    for (int i = 0; i < 100 && done_m == d0; i++) tick();
    repeat (2) tick();
    chk("bp_done_count", done_m - d0, 1);
    chk("bp_sb_empty", sb_m.size(), 0);

    // Wrapping window 1022,1023,0,1 then an aborted repeat.
    for (int i = 0; i < 4; i++) w_write(widx[i], 32'hA1 + i);
    for (int i = 0; i < 4; i++) sb_w.push_back(32'hA1 + i);
    d0 = done_w;
    w_if.dump_start = 1'b1;
    tick();
    w_if.dump_start = 1'b0;
    for (int i = 0; i < 50 && done_w == d0; i++) tick();
    tick();
    chk("wrap_done_count", done_w - d0, 1);
    chk("wrap_sb_empty", sb_w.size(), 0);

    sb_w.push_back(32'hA1);
    sb_w.push_back(32'hA2);
    d0 = done_w;
    a0 = acc_w;
    w_if.dump_start = 1'b1;
    tick();
    w_if.dump_start = 1'b0;
    for (int i = 0; i < 50 && (acc_w - a0) < 2; i++) tick();
    chk("abort_beats", acc_w - a0, 2);
    rst_w = 1'b1;
    tick();
    rst_w = 1'b0;
    chk("abort_tx_valid", w_if.tx_valid, 0);
    chk("abort_busy", w_if.dump_busy, 0);
    repeat (6) tick();
    chk("abort_no_done", done_w - d0, 0);
    chk("abort_sb_empty", sb_w.size(), 0);
    w_if.read_en = 1'b1; w_if.address = 1022;
    #1;
    chk("abort_mem_clr", w_if.data_out, 0);
    w_if.read_en = 1'b0;

`ifdef DMEM_BYTE_EN
    cpu_write(2, 32'hAABBCCDD);
    m_if.byte_en = 4'b0101;
    cpu_write(2, 32'h11223344);
    rd_chk("be_0101", 2, 32'hAA22CC44);
    m_if.byte_en = 4'b0000;
    cpu_write(2, 32'hFFFFFFFF);
    rd_chk("be_none", 2, 32'hAA22CC44);
    m_if.byte_en = '1;
`else
    cpu_write(2, 32'hAABBCCDD);
    cpu_write(2, 32'h11223344);
    rd_chk("full_word_wr", 2, 32'h11223344);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
